// File: rtl/regbank_pkg.sv
// Shared constants and types for the 8x16 register bank write side.
// The optional committed-write counter is enabled with REGBANK_WCNT_EN.
package regbank_pkg;

    localparam int WIDTH  = 16;
    localparam int NREG   = 8;
    localparam int SEL_W  = 3;
    localparam int WCNT_W = 8;

    typedef enum logic {
        IDLE   = 1'b0,
        COMMIT = 1'b1
    } state_t;

    // Saturating increment used by the committed-write counter.
    function automatic logic [WCNT_W-1:0] sat_inc(input logic [WCNT_W-1:0] value);
        return (value == {WCNT_W{1'b1}}) ? value : value + 1'b1;
    endfunction

endpackage

// File: rtl/dec3to8.sv
// Select-to-one-hot write-enable decoder for the register bank.
// Purely combinational; output is all zeros when en is low.
module dec3to8
    import regbank_pkg::*;
(
    input  logic [SEL_W-1:0] sel,
    input  logic             en,
    output logic [NREG-1:0]  onehot
);

    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[sel] = 1'b1;
        end
    end

endmodule

// File: rtl/regbank16_8w.sv
// Write side of the 8x16 general register bank: valid/ready request, one-cycle
// staging, commit with ACK pulse and per-register dirty flags. Macro REGBANK_WCNT_EN adds wcnt.
module regbank16_8w
    import regbank_pkg::*;
#(
    parameter int WIDTH   = regbank_pkg::WIDTH,
    parameter int R0_ZERO = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             w_valid,
    output logic             w_ready,
    input  logic [SEL_W-1:0] w_sel,
    input  logic [WIDTH-1:0] w_data,
    output logic             w_ack,
    output logic [NREG-1:0]  dirty,
    output logic [WIDTH-1:0] d_out0,
    output logic [WIDTH-1:0] d_out1,
    output logic [WIDTH-1:0] d_out2,
    output logic [WIDTH-1:0] d_out3,
    output logic [WIDTH-1:0] d_out4,
    output logic [WIDTH-1:0] d_out5,
    output logic [WIDTH-1:0] d_out6,
    output logic [WIDTH-1:0] d_out7
`ifdef REGBANK_WCNT_EN
    ,
    output logic [WCNT_W-1:0] wcnt
`endif
);

    state_t           state;
    state_t           state_next;
    logic             capture;
    logic             commit;
    logic             r0_drop;
    logic             wr_any;
    logic [NREG-1:0]  wr_en;
    logic [SEL_W-1:0] stage_sel;
    logic [WIDTH-1:0] stage_data;
    logic [WIDTH-1:0] regs [NREG];

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        w_ready    = 1'b0;
        capture    = 1'b0;
        commit     = 1'b0;
        unique case (state)
            IDLE: begin
                w_ready = 1'b1;
                if (w_valid) begin
                    capture    = 1'b1;
                    state_next = COMMIT;
                end
            end
            COMMIT: begin
                commit     = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else if (clr) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_sel  <= '0;
            stage_data <= '0;
        end else if (capture && !clr) begin
            stage_sel  <= w_sel;
            stage_data <= w_data;
        end
    end

    // ------------------------------------------------------------------
    // Write decode; register 0 writes are dropped when it is hardwired.
    // ------------------------------------------------------------------
    assign r0_drop = (R0_ZERO != 0) && (stage_sel == '0);
    assign wr_any  = commit && !clr && !r0_drop;

    dec3to8 u_dec (
        .sel    (stage_sel),
        .en     (wr_any),
        .onehot (wr_en)
    );

    // NOTE: the bank is flops, not RAM, so every register is reset to give defined read-mux outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
            dirty <= '0;
        end else if (clr) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
            dirty <= '0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (wr_en[i]) begin
                    regs[i] <= stage_data;
                end
            end
            dirty <= dirty | wr_en;
        end
    end

    // ACK pulses for every commit, including dropped register-0 writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_ack <= 1'b0;
        end else begin
            w_ack <= commit && !clr;
        end
    end

`ifdef REGBANK_WCNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wcnt <= '0;
        end else if (clr) begin
            wcnt <= '0;
        end else if (commit) begin
            wcnt <= sat_inc(wcnt);
        end
    end
`endif

    // ------------------------------------------------------------------
    // Parallel register outputs
    // ------------------------------------------------------------------
    assign d_out0 = (R0_ZERO != 0) ? '0 : regs[0];
    assign d_out1 = regs[1];
    assign d_out2 = regs[2];
    assign d_out3 = regs[3];
    assign d_out4 = regs[4];
    assign d_out5 = regs[5];
    assign d_out6 = regs[6];
    assign d_out7 = regs[7];

endmodule

// File: tb/tb_regbank16_8w.sv
// Self-checking bench for regbank16_8w: drives two instances (R0_ZERO=0 and R0_ZERO=1)
// with the same stimulus and compares both against a transaction-level model.
module tb_regbank16_8w;
    import regbank_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clr;
    logic        w_valid;
    logic [2:0]  w_sel;
    logic [15:0] w_data;

    logic        ready_o [2];
    logic        ack_o   [2];
    logic [7:0]  dirty_o [2];
    logic [15:0] d_o     [2][8];
    logic [7:0]  wcnt_o  [2];

    int errors = 0;
    int checks = 0;

    // Reference model: register contents, pending write, expected ACK, write count.
    logic [15:0] m_mem   [2][8];
    logic [7:0]  m_dirty [2];
    logic        m_busy  [2];
    logic [2:0]  m_psel  [2];
    logic [15:0] m_pdata [2];
    logic        m_ack   [2];
    int          m_cnt   [2];

    always #5 clk = ~clk;

    regbank16_8w #(.WIDTH(16), .R0_ZERO(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .w_valid(w_valid), .w_ready(ready_o[0]), .w_sel(w_sel), .w_data(w_data),
        .w_ack(ack_o[0]), .dirty(dirty_o[0]),
        .d_out0(d_o[0][0]), .d_out1(d_o[0][1]), .d_out2(d_o[0][2]), .d_out3(d_o[0][3]),
        .d_out4(d_o[0][4]), .d_out5(d_o[0][5]), .d_out6(d_o[0][6]), .d_out7(d_o[0][7])
`ifdef REGBANK_WCNT_EN
        , .wcnt(wcnt_o[0])
`endif
    );

    regbank16_8w #(.WIDTH(16), .R0_ZERO(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .w_valid(w_valid), .w_ready(ready_o[1]), .w_sel(w_sel), .w_data(w_data),
        .w_ack(ack_o[1]), .dirty(dirty_o[1]),
        .d_out0(d_o[1][0]), .d_out1(d_o[1][1]), .d_out2(d_o[1][2]), .d_out3(d_o[1][3]),
        .d_out4(d_o[1][4]), .d_out5(d_o[1][5]), .d_out6(d_o[1][6]), .d_out7(d_o[1][7])
`ifdef REGBANK_WCNT_EN
        , .wcnt(wcnt_o[1])
`endif
    );

`ifndef REGBANK_WCNT_EN
    initial begin
        wcnt_o[0] = '0;
        wcnt_o[1] = '0;
    end
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            for (int r = 0; r < 8; r++) m_mem[i][r] = '0;
            m_dirty[i] = '0;
            m_busy[i]  = 1'b0;
            m_psel[i]  = '0;
            m_pdata[i] = '0;
            m_ack[i]   = 1'b0;
            m_cnt[i]   = 0;
        end
    endtask

    // One clock edge of the bank's documented behaviour, from the pre-edge inputs.
    task automatic model_edge(input logic v, input logic [2:0] s, input logic [15:0] d, input logic c);
        for (int i = 0; i < 2; i++) begin
            if (c) begin
                for (int r = 0; r < 8; r++) m_mem[i][r] = '0;
                m_dirty[i] = '0;
                m_busy[i]  = 1'b0;
                m_ack[i]   = 1'b0;
                m_cnt[i]   = 0;
            end else if (m_busy[i]) begin
                if (!(i == 1 && m_psel[i] == 3'd0)) begin
                    m_mem[i][m_psel[i]]   = m_pdata[i];
                    m_dirty[i][m_psel[i]] = 1'b1;
                end
                m_ack[i]  = 1'b1;
                m_busy[i] = 1'b0;
                m_cnt[i]  = (m_cnt[i] < 255) ? m_cnt[i] + 1 : 255;
            end else begin
                m_ack[i] = 1'b0;
                if (v) begin
                    m_busy[i]  = 1'b1;
                    m_psel[i]  = s;
                    m_pdata[i] = d;
                end
            end
        end
    endtask

    task automatic check_all(input string tag, input bit with_ready);
        for (int i = 0; i < 2; i++) begin
            if (with_ready) check($sformatf("%s.i%0d.ready", tag, i), 32'(ready_o[i]), 32'(!m_busy[i]));
            check($sformatf("%s.i%0d.ack", tag, i), 32'(ack_o[i]), 32'(m_ack[i]));
            check($sformatf("%s.i%0d.dirty", tag, i), 32'(dirty_o[i]), 32'(m_dirty[i]));
            for (int r = 0; r < 8; r++)
                check($sformatf("%s.i%0d.d%0d", tag, i, r), 32'(d_o[i][r]), 32'(m_mem[i][r]));
`ifdef REGBANK_WCNT_EN
            check($sformatf("%s.i%0d.wcnt", tag, i), 32'(wcnt_o[i]), 32'(m_cnt[i]));
`endif
        end
    endtask

    // Drive inputs away from the edge, clock once, update the model, compare 1 unit later.
    task automatic step(input string tag, input logic v, input logic [2:0] s,
                        input logic [15:0] d, input logic c);
        w_valid = v;
        w_sel   = s;
        w_data  = d;
        clr     = c;
        @(posedge clk);
        model_edge(v, s, d, c);
        #1;
        check_all(tag, 1'b1);
        @(negedge clk);
    endtask

    initial begin
        rst_n   = 1'b0;
        clr     = 1'b0;
        w_valid = 1'b0;
        w_sel   = '0;
        w_data  = '0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_all("reset", 1'b1);
        step("idle", 1'b0, 3'd0, 16'h0000, 1'b0);

        // Single write to register 5.
        step("w5.acc",  1'b1, 3'd5, 16'hBEEF, 1'b0);
        step("w5.com",  1'b0, 3'd0, 16'h0000, 1'b0);
        step("w5.done", 1'b0, 3'd0, 16'h0000, 1'b0);

        // Valid held high: second request waits out the COMMIT cycle.
        step("b2b.a1", 1'b1, 3'd1, 16'h1111, 1'b0);
        step("b2b.c1", 1'b1, 3'd2, 16'h2222, 1'b0);
        step("b2b.a2", 1'b1, 3'd2, 16'h2222, 1'b0);
        step("b2b.c2", 1'b0, 3'd0, 16'h0000, 1'b0);
        step("b2b.e",  1'b0, 3'd0, 16'h0000, 1'b0);

        // Register 0 write: kept by instance 0, discarded (still ACKed) by instance 1.
        step("r0.acc", 1'b1, 3'd0, 16'hFFFF, 1'b0);
        step("r0.com", 1'b0, 3'd0, 16'h0000, 1'b0);
        step("r0.e",   1'b0, 3'd0, 16'h0000, 1'b0);

        // CLR during COMMIT drops the pending write; a same-cycle request is refused.
        step("clr.acc", 1'b1, 3'd3, 16'hAAAA, 1'b0);
        step("clr.hit", 1'b1, 3'd4, 16'h4444, 1'b1);
        step("clr.e",   1'b0, 3'd0, 16'h0000, 1'b0);

        // Randomized traffic with occasional clears.
        for (int n = 0; n < 300; n++) begin
            step($sformatf("rnd%0d", n), 1'($urandom_range(0, 9) < 7), 3'($urandom_range(0, 7)),
                 16'($urandom), 1'($urandom_range(0, 19) == 0));
        end

`ifdef REGBANK_WCNT_EN
        // Counter saturation and clear.
        step("wc.clr", 1'b0, 3'd0, 16'h0000, 1'b1);
        for (int n = 0; n < 300; n++) begin
            step("wc.acc", 1'b1, 3'($urandom_range(0, 7)), 16'($urandom), 1'b0);
            step("wc.com", 1'b0, 3'd0, 16'h0000, 1'b0);
        end
        check("wc.sat", 32'(wcnt_o[0]), 32'd255);
        step("wc.clr2", 1'b0, 3'd0, 16'h0000, 1'b1);
`endif

        // Populate a register, then reset asynchronously in the middle of a COMMIT.
        step("ar.pre", 1'b1, 3'd6, 16'h6666, 1'b0);
        step("ar.prc", 1'b0, 3'd0, 16'h0000, 1'b0);
        step("ar.acc", 1'b1, 3'd4, 16'h1234, 1'b0);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all("ar.async", 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_all("ar.rel", 1'b1);
        step("ar.idle", 1'b0, 3'd0, 16'h0000, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "simulation time limit reached");
    end

endmodule
